bram_scan_ctrl: RTL and testbench
=================================

# bram_scan_ctrl

Sequencer for the serial BRAM test harness, which exposes a single-bit `di` input, an `stb` strobe and a single-bit `do` output. On each request it shifts a parallel DIN_N-bit stimulus vector into the harness MSB-first, pulses `stb` to apply it to the RAMB36E1 pins, then shifts the DOUT_N-bit captured output back out and returns it in parallel. It sits between a bench or host-side command source and the harness's serial ports. It removes all hand-timed `di`/`stb` waveforms from minitests.

## Interface
Parameters:
- DIN_N, 8, stimulus vector width; must equal the harness DIN_N; must be ≥1
- DOUT_N, 8, response width; must equal the harness DOUT_N; must be ≥1

Ports:
- clk  in  1  single clock; also clocks the harness
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  stimulus request valid
- req_ready  out  1  controller can accept a request
- req_data  in  DIN_N  stimulus vector; bit i drives harness din[i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DOUT_N  captured harness dout vector
- busy  out  1  high in every state except IDLE
- di  out  1  to harness `di`
- stb  out  1  to harness `stb`
- do_i  in  1  from harness `do`

## Operation
- FSM states: IDLE, SHIFT, STROBE, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch req_data into vec and go to SHIFT.
- SHIFT:
  - DIN_N cycles; cycle k (k=0..DIN_N-1) drives di=vec[DIN_N-1-k].
  - Then go to STROBE.
- STROBE:
  - One cycle; stb=1, di=0.
  - Next state is DRAIN, or SHIFT when a second pass is pending (see Configuration).
- DRAIN:
  - DOUT_N cycles; di=0.
  - Each cycle, registers do_i into rsp_data LSB and shifts left, so the first sample ends in the MSB.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data is held stable.
  - On rsp_ready, go to IDLE.
- Outputs:
  - di, stb, req_ready and rsp_valid are registered or decoded from state; no combinational path from req_valid.
  - di=0 and stb=0 in IDLE, DRAIN and RESP.
- Bit counter width: $clog2(max(DIN_N,DOUT_N)+1). The counter reloads on every state entry and never wraps mid-phase.
- Reset values:
  - state=IDLE, req_ready=0 while rst_n low, then 1.
  - rsp_valid=0, rsp_data=0, di=0, stb=0, busy=0, vec=0.
- Reset mid-operation: everything returns to the reset values immediately. Harness contents are then stale but are fully overwritten by the next SHIFT. No response is emitted for the aborted request.
- A req_valid seen outside IDLE is ignored; it is not queued.

## Timing
- Acceptance edge = E0.
- di carries bit DIN_N-1 in cycle 1 and bit 0 in cycle DIN_N.
- stb is high in cycle DIN_N+1.
- do_i is sampled at the end of cycles DIN_N+2 … DIN_N+DOUT_N+1.
- rsp_valid rises in cycle DIN_N+DOUT_N+2; with defaults that is cycle 18.
- With rsp_ready held high, back-to-back requests have a period of DIN_N+DOUT_N+3 cycles (19 with defaults).
- The harness captures dout on the same edge that applies the new din. In single-pass mode the response therefore reflects the previously applied vector.

## Configuration
- Macro: BRAM_SCAN_RESHIFT_EN.
- Defined:
  - Each request runs SHIFT→STROBE twice with the same vec, then DRAIN.
  - rsp_data is the response to the current vector.
  - Latency is 2·DIN_N+DOUT_N+3 (27 with defaults).
- Undefined:
  - Single pass.
  - Response lags by one request; the first response after reset reflects harness din=0.
- A one-bit pass flag exists only when the macro is defined.

## Structure
- Shared package bram_scan_pkg holds:
  - the state enum (IDLE, SHIFT, STROBE, DRAIN, RESP);
  - defaults for DIN_N and DOUT_N;
  - a function computing the counter width.
- No sub-module is required. Both shift registers and the counter are inline. The harness stays a separate top instantiated by the bench.

## Test plan
Bench model: the harness with a behavioural BRAM stand-in, dout = ~din.
- Reset: assert rst_n=0 mid-idle → all outputs zero; req_ready=1 one cycle after release.
- Waveform check: request 8'hA5 → di sequence 1,0,1,0,0,1,0,1 in cycles 1–8; stb high only in cycle 9; rsp_valid in cycle 18.
- Single-pass lag (macro off): requests 8'hA5 then 8'h3C → responses 8'hFF then 8'h5A.
- Reshift (macro on): request 8'hA5 → response 8'h5A at cycle 27; stb high in cycles 9 and 18.
- Backpressure: hold rsp_ready low for 5 cycles → rsp_data stable, req_ready low, busy high, stray req_valid ignored.
- Abort: pulse rst_n low in SHIFT cycle 4 → outputs return to reset values; next request 8'h3C then completes with the correct latency, and with the macro on returns 8'hC3.

Source files
------------

// File: rtl/bram_scan_pkg.sv
// bram_scan_pkg
//   Shared definitions for the serial BRAM harness sequencer:
//   - state_e     : controller states (IDLE, SHIFT, STROBE, DRAIN, RESP)
//   - DIN_N_DEF   : default stimulus vector width
//   - DOUT_N_DEF  : default response vector width
//   - cnt_width() : bit-counter width able to hold max(DIN_N, DOUT_N)
package bram_scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    STROBE = 3'd2,
    DRAIN  = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam int DIN_N_DEF  = 8;
  localparam int DOUT_N_DEF = 8;

  // Counter width wide enough for the longer of the two serial phases.
  function automatic int cnt_width(input int din_n, input int dout_n);
    return $clog2(((din_n > dout_n) ? din_n : dout_n) + 1);
  endfunction

endpackage

// File: rtl/bram_scan_ctrl.sv
// bram_scan_ctrl
//   Sequencer for the serial BRAM test harness. A request's parallel stimulus
//   is shifted MSB-first into the harness on di, applied with a one-cycle stb
//   pulse, and the harness response is shifted back in from do_i and returned
//   in parallel.
//
//   Optional feature (macro BRAM_SCAN_RESHIFT_EN): every request runs the
//   SHIFT/STROBE pair twice with the same vector so that the response belongs
//   to the current vector rather than the previous one.
//
// Ports
//   clk        in   clock (also clocks the harness)
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   stimulus request valid
//   req_ready  out  controller can accept a request (IDLE only)
//   req_data   in   DIN_N stimulus vector; bit i drives harness din[i]
//   rsp_valid  out  response valid (RESP only)
//   rsp_ready  in   consumer accepts the response
//   rsp_data   out  DOUT_N captured harness dout vector
//   busy       out  high in every state except IDLE
//   di         out  serial data to the harness
//   stb        out  strobe to the harness
//   do_i       in   serial data from the harness
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready and rsp_valid are registered, with no combinational
// path from req_valid or rsp_ready. A req_valid outside IDLE is dropped.
module bram_scan_ctrl
  import bram_scan_pkg::*;
#(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIN_N-1:0]  req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DOUT_N-1:0] rsp_data,
  output logic              busy,
  output logic              di,
  output logic              stb,
  input  logic              do_i
);

  localparam int CW = cnt_width(DIN_N, DOUT_N);

  state_e           state;
  logic [DIN_N-1:0] vec;
  logic [CW-1:0]    cnt;
`ifdef BRAM_SCAN_RESHIFT_EN
  logic             pass;
`endif

  // vec is rotated rather than shifted, so after a full SHIFT phase it is
  // back to the original request and can be replayed by a second pass.
  function automatic logic [DIN_N-1:0] rotl(input logic [DIN_N-1:0] v);
    return (v << 1) | (v >> (DIN_N - 1));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      di        <= 1'b0;
      stb       <= 1'b0;
      busy      <= 1'b0;
      vec       <= '0;
      cnt       <= '0;
`ifdef BRAM_SCAN_RESHIFT_EN
      pass      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            // di is registered: present the MSB in the first SHIFT cycle.
            state     <= SHIFT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            di        <= req_data[DIN_N-1];
            vec       <= rotl(req_data);
            cnt       <= CW'(DIN_N - 1);
`ifdef BRAM_SCAN_RESHIFT_EN
            pass      <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (cnt == '0) begin
            state <= STROBE;
            di    <= 1'b0;
            stb   <= 1'b1;
          end else begin
            di  <= vec[DIN_N-1];
            vec <= rotl(vec);
            cnt <= cnt - CW'(1);
          end
        end

        STROBE: begin
          stb <= 1'b0;
`ifdef BRAM_SCAN_RESHIFT_EN
          if (!pass) begin
            // Replay the same vector so the next strobe captures its response.
            state <= SHIFT;
            pass  <= 1'b1;
            di    <= vec[DIN_N-1];
            vec   <= rotl(vec);
            cnt   <= CW'(DIN_N - 1);
          end else begin
            state <= DRAIN;
            cnt   <= CW'(DOUT_N - 1);
          end
`else
          state <= DRAIN;
          cnt   <= CW'(DOUT_N - 1);
`endif
        end

        DRAIN: begin
          // First sample ends up in the MSB after DOUT_N shifts.
          rsp_data <= (rsp_data << 1) | DOUT_N'(do_i);
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          di        <= 1'b0;
          stb       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// tb_bram_scan_ctrl
//   Bench for bram_scan_ctrl with a behavioural serial harness whose BRAM
//   stand-in returns dout = ~din. Expected responses come from a
//   transaction-level model of the harness (last applied vector).
module tb_bram_scan_ctrl;

  localparam int DIN_N  = 8;
  localparam int DOUT_N = 8;
`ifdef BRAM_SCAN_RESHIFT_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LAT = NPASS * (DIN_N + 1) + DOUT_N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DIN_N-1:0]  req_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DOUT_N-1:0] rsp_data;
  logic              busy;
  logic              di;
  logic              stb;
  logic              do_i;

  bram_scan_ctrl #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .di        (di),
    .stb       (stb),
    .do_i      (do_i)
  );

  // ---------------- harness stand-in (no reset, like the real one) ----------
  logic [DIN_N-1:0]  h_sr = '0;
  logic [DIN_N-1:0]  h_applied = '0;
  logic [DOUT_N-1:0] h_out = '0;
  always @(posedge clk) begin
    h_sr <= {h_sr[DIN_N-2:0], di};
    if (stb) begin
      h_applied <= h_sr;
      h_out     <= ~h_applied;
    end else begin
      h_out <= {h_out[DOUT_N-2:0], 1'b0};
    end
  end
  assign do_i = h_out[DOUT_N-1];

  // ---------------- scoreboard / model ----------------
  logic [DOUT_N-1:0] exp_q[$];
  logic [DIN_N-1:0]  model_applied = '0;
  int n_cmp = 0;
  int n_err = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction model: the harness captures ~(previously applied din) on
  // each strobe, then applies the new din.
  function automatic logic [DOUT_N-1:0] model_request(input logic [DIN_N-1:0] v);
    logic [DOUT_N-1:0] r;
    if (NPASS == 2) r = ~v;
    else            r = ~model_applied;
    model_applied = v;
    return r;
  endfunction

  function automatic logic exp_di(input logic [DIN_N-1:0] v, input int c);
    for (int p = 0; p < NPASS; p++) begin
      int base = p * (DIN_N + 1);
      if (c >= base + 1 && c <= base + DIN_N) return v[DIN_N-1-(c-base-1)];
    end
    return 1'b0;
  endfunction

  function automatic logic exp_stb(input int c);
    for (int p = 0; p < NPASS; p++)
      if (c == p * (DIN_N + 1) + DIN_N + 1) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data",  {56'd0, rsp_data},  64'd0);
    check("rst_di",        {63'd0, di},        64'd0);
    check("rst_stb",       {63'd0, stb},       64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("ready_at_release", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_release", {63'd0, req_ready}, 64'd1);
  endtask

  // One full request with waveform, latency, backpressure and stray-request checks.
  task automatic send(input logic [DIN_N-1:0] v, input int hold);
    logic [63:0] obs_di, obs_stb, want_di, want_stb;
    int c;
    wait_ready();
    req_valid = 1'b1;
    req_data  = v;
    exp_q.push_back(model_request(v));
    @(negedge clk);                       // cycle 1
    acc_cyc = cyc;
    req_valid = 1'b0;
    check("busy_after_accept", {62'd0, busy, req_ready}, 64'd2);
    obs_di = '0; obs_stb = '0; want_di = '0; want_stb = '0;
    c = 1;
    while (!rsp_valid && c < 100) begin
      if (c < 64) begin
        obs_di[c]   = di;
        obs_stb[c]  = stb;
        want_di[c]  = exp_di(v, c);
        want_stb[c] = exp_stb(c);
      end
      // Stray requests while busy must be dropped.
      req_valid = 1'($urandom_range(0, 1));
      req_data  = DIN_N'($urandom);
      @(negedge clk);
      c++;
    end
    req_valid = 1'b0;
    check("di_wave",     obs_di,  want_di);
    check("stb_wave",    obs_stb, want_stb);
    check("rsp_latency", 64'(c),  64'(LAT));
    if (!rsp_valid) begin
      check("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_state", {61'd0, rsp_valid, req_ready, busy}, 64'b101);
      check("hold_data",  {56'd0, rsp_data}, {56'd0, exp_q[0]});
      req_valid = 1'b1;
      req_data  = DIN_N'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("rsp_data", {56'd0, rsp_data}, {56'd0, exp_q.pop_front()});
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", {61'd0, rsp_valid, req_ready, busy}, 64'b010);
  endtask

  // Request aborted by a reset pulse in SHIFT cycle 4.
  task automatic send_abort(input logic [DIN_N-1:0] v);
    wait_ready();
    req_valid = 1'b1;
    req_data  = v;
    @(negedge clk);                       // cycle 1
    req_valid = 1'b0;
    repeat (3) @(negedge clk);            // cycle 4
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {55'd0, rsp_data, req_ready, rsp_valid, di, stb, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", {62'd0, req_ready, busy}, 64'b10);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int first_acc;
    do_reset();

    // Directed: A5 then 3C, back to back (period check).
    send(8'hA5, 0);
    first_acc = acc_cyc;
    send(8'h3C, 0);
    check("b2b_period", 64'(acc_cyc - first_acc), 64'(LAT + 1));

    // Backpressure with stray requests.
    send(8'h96, 5);

    // Reset while idle; harness keeps its contents.
    do_reset();

    // Abort mid-shift, then a clean request.
    send_abort(8'hF0);
    send(8'h3C, 2);

    // Randomized traffic.
    for (int i = 0; i < 12; i++)
      send(DIN_N'($urandom), $urandom_range(0, 4));

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
